// File: rtl/api_slave_pkg.sv
// rtl/api_slave_pkg.sv - frame geometry, idle pattern and state encoding shared with the master controller
package api_slave_pkg;

  localparam int          API_WORK_LEN     = 23;
  localparam int          API_RX_BLOCK_LEN = 11;
  localparam int          API_NUM          = 1;
  localparam int          API_WORD_W       = 32;
  localparam logic [31:0] API_IDLE_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } api_state_e;

endpackage

// File: rtl/api_slave_ram.sv
// rtl/api_slave_ram.sv - result FIFO storage, one write port and one asynchronous read port
module api_slave_ram
  import api_slave_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [API_WORD_W-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [API_WORD_W-1:0] o_rd_data
);

  logic [API_WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/api_slave.sv
// rtl/api_slave.sv - serial work-frame slave with result FIFO returned as miso blocks
module api_slave
  import api_slave_pkg::*;
#(
  parameter int WORK_LEN     = API_WORK_LEN,
  parameter int RX_BLOCK_LEN = API_RX_BLOCK_LEN,
  parameter int RES_DEPTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         sck,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         work_vld,
  output logic [31:0]                  work_dat,
  output logic [4:0]                   work_idx,
  output logic                         frame_done,
  output logic                         frame_abort,
  input  logic                         res_wr_en,
  input  logic [31:0]                  res_din,
  output logic                         res_full,
  output logic [$clog2(RES_DEPTH):0]   res_count
);

  localparam int             AW         = $clog2(RES_DEPTH);
  localparam logic [4:0]     C_WORK_LEN = WORK_LEN[4:0];
  localparam logic [4:0]     C_BLK_LEN  = RX_BLOCK_LEN[4:0];
  localparam logic [4:0]     C_BLK_LAST = C_BLK_LEN - 5'd1;
  localparam logic [AW-1:0]  C_BLK_PTR  = RX_BLOCK_LEN[AW-1:0];
  localparam logic [AW:0]    C_BLK_CNT  = RX_BLOCK_LEN[AW:0];
  localparam logic [AW:0]    C_DEPTH    = RES_DEPTH[AW:0];

  // Synchronizers reset low so a load already held low at reset release is not seen as a fall.
  logic [1:0] r_load_sync, r_sck_sync, r_mosi_sync;
  logic       r_load_d, r_sck_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_sync <= '0;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_load_d    <= 1'b0;
      r_sck_d     <= 1'b0;
    end else begin
      r_load_sync <= {r_load_sync[0], load};
      r_sck_sync  <= {r_sck_sync[0], sck};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_load_d    <= r_load_sync[1];
      r_sck_d     <= r_sck_sync[1];
    end
  end

  logic w_load_s, w_load_fall, w_load_rise, w_sck_rise, w_sck_fall, w_mosi_s;
  assign w_load_s    = r_load_sync[1];
  assign w_load_fall = ~w_load_s & r_load_d;
  assign w_load_rise = w_load_s & ~r_load_d;
  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_sync[1] & r_sck_d;
  assign w_mosi_s    = r_mosi_sync[1];

  api_state_e  r_state, w_state_nxt;
  logic [4:0]  r_bit_cnt, r_word_cnt;
  logic [31:0] r_rx_sr, r_tx_sr;
  logic        r_live;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic        r_work_vld, r_frame_done, r_frame_abort;
  logic [31:0] r_work_dat;
  logic [4:0]  r_work_idx;
  logic        w_start, w_done_evt, w_abort_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done_evt  = 1'b0;
    w_abort_evt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_load_rise) begin
          w_state_nxt = ST_IDLE;
          if (r_word_cnt == C_WORK_LEN) begin
            w_done_evt = 1'b1;
          end else begin
            w_abort_evt = 1'b1;
          end
        end else if (r_word_cnt == C_WORK_LEN) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_load_rise) begin
          w_state_nxt = ST_IDLE;
          w_done_evt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic          w_full, w_wr, w_active, w_word_end, w_commit;
  logic          w_live_sel, w_in_block;
  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_rd_data, w_tx_word;

  assign w_full     = (r_count == C_DEPTH);
  assign w_wr       = res_wr_en & ~w_full;
  assign w_active   = (r_state == ST_SHIFT) && (r_word_cnt != C_WORK_LEN);
  assign w_word_end = w_active & w_sck_rise & (r_bit_cnt == 5'd31);
  assign w_commit   = w_word_end & r_live & (r_word_cnt == C_BLK_LAST);

  // Block words are peeked at rd_ptr + word index; only the commit point consumes them.
  assign w_rd_addr  = (r_state == ST_IDLE) ? r_rd_ptr : r_rd_ptr + AW'(r_word_cnt);
  assign w_live_sel = w_start ? (r_count >= C_BLK_CNT) : r_live;
  assign w_in_block = w_start | (r_word_cnt < C_BLK_LEN);
  assign w_tx_word  = (w_live_sel && w_in_block) ? w_rd_data : API_IDLE_WORD;

  api_slave_ram #(
    .DEPTH (RES_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (res_din),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_rx_sr       <= '0;
      r_tx_sr       <= '1;
      r_live        <= 1'b0;
      r_work_vld    <= 1'b0;
      r_work_dat    <= '0;
      r_work_idx    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_work_vld    <= 1'b0;
      r_frame_done  <= w_done_evt;
      r_frame_abort <= w_abort_evt;
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_live     <= w_live_sel;
        r_tx_sr    <= w_tx_word;
      end else if (w_active) begin
        if (w_sck_rise) begin
          r_rx_sr <= {r_rx_sr[30:0], w_mosi_s};
          if (r_bit_cnt == 5'd31) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= r_word_cnt + 5'd1;
            r_work_vld <= 1'b1;
            r_work_dat <= {r_rx_sr[30:0], w_mosi_s};
            r_work_idx <= r_word_cnt;
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        // A fall with bit_cnt at 0 follows the last rise of a word: load the next word.
        if (w_sck_fall) begin
          if (r_bit_cnt == 5'd0) begin
            r_tx_sr <= w_tx_word;
          end else begin
            r_tx_sr <= {r_tx_sr[30:0], 1'b1};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_commit) begin
        r_rd_ptr <= r_rd_ptr + C_BLK_PTR;
      end
      unique case ({w_wr, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - C_BLK_CNT;
        2'b11:   r_count <= r_count + 1'b1 - C_BLK_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  assign miso        = (r_state == ST_SHIFT && !w_load_s) ? r_tx_sr[31] : 1'b1;
  assign work_vld    = r_work_vld;
  assign work_dat    = r_work_dat;
  assign work_idx    = r_work_idx;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign res_full    = w_full;
  assign res_count   = r_count;

endmodule

// File: tb/tb_api_slave.sv
// tb/tb_api_slave.sv - directed self-checking bench for api_slave
module tb_api_slave;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst, load, sck, mosi, miso;
  logic        work_vld, frame_done, frame_abort;
  logic [31:0] work_dat;
  logic [4:0]  work_idx;
  logic        res_wr_en, res_full;
  logic [31:0] res_din;
  logic [5:0]  res_count;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] vld_dat [64];
  logic [4:0]  vld_idx [64];

  always #5 clk = ~clk;

  api_slave dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .work_vld    (work_vld),
    .work_dat    (work_dat),
    .work_idx    (work_idx),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .res_wr_en   (res_wr_en),
    .res_din     (res_din),
    .res_full    (res_full),
    .res_count   (res_count)
  );

  always @(negedge clk) begin
    if (work_vld) begin
      vld_dat[vld_cnt % 64] = work_dat;
      vld_idx[vld_cnt % 64] = work_idx;
      vld_cnt++;
    end
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic spi_bit(input logic b, input logic wr_hit, output logic m);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m   = miso;
    sck = 1'b1;
    if (wr_hit) begin
      @(negedge clk);
      @(negedge clk);
      res_wr_en = 1'b1;
      res_din   = 32'hC0DE_0001;
      @(negedge clk);
      res_wr_en = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    sck = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] tx, input logic wr_hit, output logic [31:0] rx);
    logic b;
    for (int i = 31; i >= 0; i--) begin
      spi_bit(tx[i], wr_hit && (i == 0), b);
      rx[i] = b;
    end
  endtask

  task automatic fifo_write(input logic [31:0] d);
    res_wr_en = 1'b1;
    res_din   = d;
    @(negedge clk);
    res_wr_en = 1'b0;
  endtask

  task automatic select_frame();
    load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic deselect_frame();
    repeat (4) @(negedge clk);
    load = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_count(input string name, input logic [5:0] exp);
    n_checks++;
    if (res_count !== exp) begin
      n_fail++;
      $display("FAIL %s res_count got %0d exp %0d", name, res_count, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; sck = 1'b0; mosi = 1'b0;
    res_wr_en = 1'b0; res_din = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({miso, work_vld, frame_done, frame_abort, res_full} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 10000", {miso, work_vld, frame_done, frame_abort, res_full});
    end
    n_checks++;
    if (work_dat !== 32'h0 || work_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_work got %h/%0d exp 0/0", work_dat, work_idx);
    end
    check_count("reset", 6'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_int("reset_miso_idle", int'(miso), 1);
  endtask

  task automatic test_live_frame();
    logic [31:0] rx, exp;
    int v0, d0, a0;
    for (int i = 0; i < 11; i++) fifo_write(32'h1000_0000 + 32'(i));
    check_count("live_fill", 6'd11);
    v0 = vld_cnt; d0 = done_cnt; a0 = abort_cnt;
    select_frame();
    for (int w = 0; w < 23; w++) begin
      spi_word(32'(w), 1'b0, rx);
      exp = (w < 11) ? 32'h1000_0000 + 32'(w) : 32'h0;
      n_checks++;
      if (rx !== exp) begin
        n_fail++;
        $display("FAIL live_miso_w%0d got %h exp %h", w, rx, exp);
      end
    end
    deselect_frame();
    check_int("live_vld_count", vld_cnt - v0, 23);
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (vld_idx[(v0 + i) % 64] !== 5'(i) || vld_dat[(v0 + i) % 64] !== 32'(i)) begin
        n_fail++;
        $display("FAIL live_work_%0d got idx %0d dat %h exp idx %0d dat %h",
                 i, vld_idx[(v0 + i) % 64], vld_dat[(v0 + i) % 64], i, i);
      end
    end
    check_int("live_done", done_cnt - d0, 1);
    check_int("live_abort", abort_cnt - a0, 0);
    check_count("live_drain", 6'd0);
    check_int("live_miso_after", int'(miso), 1);
  endtask

  task automatic test_empty_fifo();
    logic [31:0] rx;
    int d0, v0;
    for (int i = 0; i < 5; i++) fifo_write(32'h2000_0000 + 32'(i));
    check_count("empty_fill", 6'd5);
    d0 = done_cnt; v0 = vld_cnt;
    select_frame();
    for (int w = 0; w < 23; w++) begin
      spi_word(32'hFFFF_0000 | 32'(w), 1'b0, rx);
      n_checks++;
      if (rx !== 32'h0) begin
        n_fail++;
        $display("FAIL empty_miso_w%0d got %h exp 00000000", w, rx);
      end
    end
    deselect_frame();
    check_int("empty_vld_count", vld_cnt - v0, 23);
    check_int("empty_done", done_cnt - d0, 1);
    check_count("empty_keep", 6'd5);
    for (int i = 5; i < 11; i++) fifo_write(32'h2000_0000 + 32'(i));
    check_count("empty_refill", 6'd11);
  endtask

  task automatic test_abort();
    logic [31:0] rx, exp;
    logic b;
    int v0, d0, a0;
    v0 = vld_cnt; d0 = done_cnt; a0 = abort_cnt;
    select_frame();
    for (int w = 0; w < 7; w++) begin
      spi_word(32'hA5A5_0000 + 32'(w), 1'b0, rx);
      n_checks++;
      if (rx !== 32'h2000_0000 + 32'(w)) begin
        n_fail++;
        $display("FAIL abort_miso_w%0d got %h exp %h", w, rx, 32'h2000_0000 + 32'(w));
      end
    end
    for (int i = 0; i < 13; i++) spi_bit(1'b1, 1'b0, b);
    deselect_frame();
    check_int("abort_vld_count", vld_cnt - v0, 7);
    check_int("abort_pulse", abort_cnt - a0, 1);
    check_int("abort_no_done", done_cnt - d0, 0);
    check_count("abort_keep", 6'd11);
    d0 = done_cnt;
    select_frame();
    for (int w = 0; w < 23; w++) begin
      spi_word(32'(w), 1'b0, rx);
      exp = (w < 11) ? 32'h2000_0000 + 32'(w) : 32'h0;
      n_checks++;
      if (rx !== exp) begin
        n_fail++;
        $display("FAIL resend_miso_w%0d got %h exp %h", w, rx, exp);
      end
    end
    deselect_frame();
    check_int("resend_done", done_cnt - d0, 1);
    check_count("resend_drain", 6'd0);
  endtask

  task automatic test_full_fifo();
    logic [31:0] rx, exp;
    for (int i = 0; i < 32; i++) fifo_write(32'h3000_0000 + 32'(i));
    check_int("full_at_32", int'(res_full), 1);
    check_count("full_32", 6'd32);
    fifo_write(32'h3000_0020);
    check_count("full_drop", 6'd32);
    select_frame();
    for (int w = 0; w < 23; w++) begin
      spi_word(32'(w), 1'b0, rx);
      exp = (w < 11) ? 32'h3000_0000 + 32'(w) : 32'h0;
      n_checks++;
      if (rx !== exp) begin
        n_fail++;
        $display("FAIL full_miso_w%0d got %h exp %h", w, rx, exp);
      end
    end
    deselect_frame();
    check_count("full_after_frame", 6'd21);
    check_int("full_cleared", int'(res_full), 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx, exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_count("b2b_reset", 6'd0);
    for (int i = 0; i < 11; i++) fifo_write(32'h4000_0000 + 32'(i));
    select_frame();
    for (int w = 0; w < 23; w++) begin
      spi_word(32'(w), w == 10, rx);
      exp = (w < 11) ? 32'h4000_0000 + 32'(w) : 32'h0;
      n_checks++;
      if (rx !== exp) begin
        n_fail++;
        $display("FAIL b2b_miso_w%0d got %h exp %h", w, rx, exp);
      end
    end
    deselect_frame();
    check_count("b2b_commit_write", 6'd1);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    int v0, d0, a0;
    select_frame();
    for (int w = 0; w < 3; w++) spi_word(32'hBEEF_0000 + 32'(w), 1'b0, rx);
    v0 = vld_cnt; d0 = done_cnt; a0 = abort_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_int("mid_miso_after_rst", int'(miso), 1);
    spi_word(32'h5555_AAAA, 1'b0, rx);
    n_checks++;
    if (rx !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mid_miso_word got %h exp ffffffff", rx);
    end
    deselect_frame();
    check_int("mid_no_vld", vld_cnt - v0, 0);
    check_int("mid_no_done", done_cnt - d0, 0);
    check_int("mid_no_abort", abort_cnt - a0, 0);
    select_frame();
    spi_word(32'h1234_5678, 1'b0, rx);
    deselect_frame();
    check_int("mid_new_vld", vld_cnt - v0, 1);
    n_checks++;
    if (vld_idx[v0 % 64] !== 5'd0 || vld_dat[v0 % 64] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mid_new_word got idx %0d dat %h exp idx 0 dat 12345678",
               vld_idx[v0 % 64], vld_dat[v0 % 64]);
    end
    check_int("mid_new_abort", abort_cnt - a0, 1);
  endtask

  initial begin
    test_reset();
    test_live_frame();
    test_empty_fifo();
    test_abort();
    test_full_fifo();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
